pes_seq_det_prog_fsm: RTL and testbench
=======================================

// Module: pes_seq_det_prog_fsm
// PURPOSE
//  Programmable serial bit-sequence detector. Generational successor to the fixed-pattern detector.
//  Pattern, pattern length (1..MAX_LEN) and overlap mode load at runtime.
//  Input is valid-qualified. Output is a registered one-cycle match pulse plus a saturating match counter.
//  Sits between the serial front-end bit stream and the event/interrupt logic.
// PARAMETERS
//  MAX_LEN  8   maximum pattern length in bits (>=2)
//  CNT_W    16  width of match_count
// PORTS
//  clock         in   1                     single clock, all logic on rising edge
//  reset         in   1                     synchronous, active-high
//  cfg_load      in   1                     load cfg_* this cycle
//  cfg_pattern   in   MAX_LEN               bit[cfg_len-1] = first bit received, bit[0] = last
//  cfg_len       in   $clog2(MAX_LEN+1)     pattern length; legal range 1..MAX_LEN
//  cfg_overlap   in   1                     1 = overlapping matches, 0 = non-overlapping
//  sequence_in   in   1                     serial data bit
//  in_valid      in   1                     sequence_in is sampled only when this is high
//  detector_out  out  1                     one-cycle match pulse
//  match_count   out  CNT_W                 number of matches since last valid load, saturating
//  cfg_err       out  1                     last load was illegal (sticky)
//  armed         out  1                     high while state == S_HUNT
// BEHAVIOUR
//  Reset: all outputs 0; state S_UNCFG; hist, fill, pattern, len, overlap all 0.
//  FSM:
//   S_UNCFG --valid load--> S_HUNT
//   any --illegal load (len 0 or >MAX_LEN)--> S_ERR
//   S_ERR --valid load--> S_HUNT
//   S_HUNT --valid load--> S_HUNT, reinitialised
//  Valid load:
//   - latch pattern, len and overlap.
//   - clear hist, fill, match_count and cfg_err.
//   - drop in_valid in the load cycle; that bit is discarded.
//  Illegal load:
//   - set cfg_err; keep previous config registers.
//   - in S_ERR, detector_out and match_count stay frozen/0 until the next valid load.
//  Hunting (S_HUNT, in_valid=1, no cfg_load):
//   - nh = {hist[MAX_LEN-2:0], sequence_in}; mask = low len bits set.
//   - match = ((nh & mask) == (pattern & mask)) && (fill+1 >= len).
//   - hist <= nh; fill <= min(fill+1, MAX_LEN).
//   - On match with overlap=0: fill <= 0, so the next match needs len fresh bits.
//   - On match with overlap=1: fill is not reset (clamped).
//  Latency: bit sampled at edge k -> detector_out high for exactly the cycle following edge k.
//   - in_valid=0: hist/fill hold, detector_out=0.
//  match_count increments on each match and saturates at all-ones (no wrap).
//  Simultaneous cfg_load and in_valid: load wins, bit discarded, detector_out=0.
//  reset mid-stream: partial history lost; no pulse for the completing bit; block returns to S_UNCFG.
//  cfg_len=1: every valid bit equal to pattern[0] matches.
// STRUCTURE
//  Include pes_seq_det_pkg.vh holds:
//   - state encodings S_UNCFG=2'd0, S_HUNT=2'd1, S_ERR=2'd2;
//   - LEN_W = $clog2(MAX_LEN+1).
//  Sub-module pes_seq_det_window: hist shift register, fill counter and masked compare.
//   - interface: shift_en, clear, nonovl_clr -> match.
//   - Top holds the FSM, config registers, output pulse register and counter.
// TESTING
//  1. pattern=5'b10101 len=5 overlap=1, stream 1010101 -> pulses after bits 5 and 7; match_count=2.
//  2. Same pattern, overlap=0, stream 1010101 -> single pulse after bit 5; match_count=1.
//  3. len=5 10101 with in_valid low for 3 cycles between bits 2 and 3 -> one pulse after 5th valid bit;
//     no pulse during gaps.
//  4. cfg_len=0 -> cfg_err=1, armed=0, stream 10101... gives no pulse.
//     Then load len=3 pattern 3'b011, stream 011 -> cfg_err=0, pulse after 3rd bit.
//  5. CNT_W=2, MAX_LEN=8, len=8 pattern 8'hA5, overlap=0, 4 back-to-back A5 bytes
//     -> 4 pulses; match_count stops at 3.
//  6. len=5 10101: drive 1010, assert reset one cycle, then drive 1
//     -> no pulse; armed=0; match_count=0.
//     Also: cfg_load coincident with in_valid -> bit ignored.

Source files
------------

// File: rtl/pes_seq_det_pkg.sv
// Shared types and constants for the programmable sequence detector.
//   state_t : FSM encoding (S_UNCFG, S_HUNT, S_ERR)
//   len_w() : width of a length field able to hold 0..max_len
package pes_seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    S_UNCFG = 2'd0,
    S_HUNT  = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pes_seq_det_window.sv
// Bit history window: shift register, fill counter and masked pattern compare.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   shift_en      : accept bit_in this cycle
//   clear         : drop history and fill (new configuration)
//   nonovl_clr    : restart fill after a match (non-overlapping mode)
//   bit_in        : serial data bit
//   pattern, len  : active pattern and its length
//   match_c       : combinational; bit_in completes a match this cycle
module pes_seq_det_window
  import pes_seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               nonovl_clr,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match_c
);

  localparam int unsigned FW = LEN_W + 1;

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] nh;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [FW-1:0]      fill_inc;

  // Candidate history and compare; newest bit sits at position 0.
  always_comb begin
    nh   = {hist[MAX_LEN-2:0], bit_in};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    fill_inc = FW'(fill) + FW'(1);
    match_c  = shift_en
            && ((nh & mask) == (pattern & mask))
            && (fill_inc >= FW'(len));
  end

  // History and fill bookkeeping; fill saturates at MAX_LEN.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= nh;
      if (match_c && nonovl_clr) begin
        fill <= '0;
      end else if (fill_inc > FW'(MAX_LEN)) begin
        fill <= LEN_W'(MAX_LEN);
      end else begin
        fill <= fill_inc[LEN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pes_seq_det_prog_fsm.sv
// Programmable serial bit-sequence detector with runtime pattern/length/overlap.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   cfg_load      : load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern   : bit[cfg_len-1] is first bit received, bit[0] is last
//   cfg_len       : pattern length, legal 1..MAX_LEN
//   cfg_overlap   : 1 = overlapping matches allowed
//   sequence_in   : serial data bit, qualified by in_valid
//   in_valid      : sequence_in valid this cycle
//   detector_out  : one-cycle match pulse (registered)
//   match_count   : matches since last valid load, saturating
//   cfg_err       : last load was illegal (sticky until a valid load)
//   armed         : high while hunting for the pattern
module pes_seq_det_prog_fsm
  import pes_seq_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter  int unsigned CNT_W   = DEF_CNT_W,
  localparam int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               sequence_in,
  input  logic               in_valid,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;

  logic legal_c;
  logic load_ok_c;
  logic shift_en_c;
  logic match_c;

  // A load always wins over a coincident data bit.
  always_comb begin
    legal_c    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    load_ok_c  = cfg_load && legal_c;
    shift_en_c = (state == S_HUNT) && in_valid && !cfg_load;
  end

  pes_seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clock      (clock),
    .reset      (reset),
    .shift_en   (shift_en_c),
    .clear      (load_ok_c),
    .nonovl_clr (!overlap_q),
    .bit_in     (sequence_in),
    .pattern    (pattern_q),
    .len        (len_q),
    .match_c    (match_c)
  );

  // FSM, configuration registers, match pulse and saturating counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_UNCFG;
      pattern_q    <= '0;
      len_q        <= '0;
      overlap_q    <= 1'b0;
      detector_out <= 1'b0;
      match_count  <= '0;
      cfg_err      <= 1'b0;
      armed        <= 1'b0;
    end else begin
      detector_out <= 1'b0;
      if (cfg_load) begin
        if (legal_c) begin
          state       <= S_HUNT;
          armed       <= 1'b1;
          cfg_err     <= 1'b0;
          match_count <= '0;
          pattern_q   <= cfg_pattern;
          len_q       <= cfg_len;
          overlap_q   <= cfg_overlap;
        end else begin
          // Illegal load keeps the old config but stops hunting.
          state   <= S_ERR;
          armed   <= 1'b0;
          cfg_err <= 1'b1;
        end
      end else if (match_c) begin
        detector_out <= 1'b1;
        if (match_count != '1) begin
          match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pes_seq_det_prog_fsm.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based behavioural model; a second instance with a 2-bit counter
// exercises saturation.
module tb_pes_seq_det_prog_fsm;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               sequence_in;
  logic               in_valid;
  logic               detector_out;
  logic [15:0]        match_count;
  logic               cfg_err;
  logic               armed;
  logic               detector_out2;
  logic [1:0]         match_count2;
  logic               cfg_err2;
  logic               armed2;

  always #5 clock = ~clock;

  pes_seq_det_prog_fsm #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .sequence_in(sequence_in),
    .in_valid(in_valid), .detector_out(detector_out), .match_count(match_count),
    .cfg_err(cfg_err), .armed(armed)
  );

  pes_seq_det_prog_fsm #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .sequence_in(sequence_in),
    .in_valid(in_valid), .detector_out(detector_out2), .match_count(match_count2),
    .cfg_err(cfg_err2), .armed(armed2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: queue of bits eligible to take part in the next match.
  bit               m_armed;
  bit               m_err;
  bit               m_pulse;
  logic [7:0]       m_pat;
  int               m_len;
  bit               m_ovl;
  int unsigned      m_cnt;
  int unsigned      m_cnt2;
  bit               q[$];

  function automatic void model_step(input bit rst, input bit ld, input logic [7:0] pat,
                                     input int ln, input bit ov, input bit v, input bit b);
    bit hit;
    if (rst) begin
      m_armed = 0; m_err = 0; m_pulse = 0; m_pat = '0; m_len = 0; m_ovl = 0;
      m_cnt = 0; m_cnt2 = 0; q.delete();
      return;
    end
    m_pulse = 0;
    if (ld) begin
      if (ln >= 1 && ln <= int'(MAX_LEN)) begin
        m_pat = pat; m_len = ln; m_ovl = ov; m_armed = 1; m_err = 0;
        m_cnt = 0; m_cnt2 = 0; q.delete();
      end else begin
        m_err = 1; m_armed = 0;
      end
    end else if (m_armed && v) begin
      q.push_back(b);
      if (q.size() > int'(MAX_LEN)) q.delete(0);
      hit = (q.size() >= m_len);
      if (hit) begin
        for (int i = 0; i < m_len; i++) begin
          if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
        end
      end
      if (hit) begin
        m_pulse = 1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!m_ovl) q.delete();
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs after the edge.
  task automatic step(input bit rst, input bit ld, input logic [7:0] pat,
                      input logic [3:0] ln, input bit ov, input bit v, input bit b);
    reset = rst; cfg_load = ld; cfg_pattern = pat; cfg_len = ln;
    cfg_overlap = ov; in_valid = v; sequence_in = b;
    model_step(rst, ld, pat, int'(ln), ov, v, b);
    @(posedge clock);
    #1;
    chk("detector_out", int'(detector_out), int'(m_pulse));
    chk("match_count", int'(match_count), int'(m_cnt));
    chk("cfg_err", int'(cfg_err), int'(m_err));
    chk("armed", int'(armed), int'(m_armed));
    chk("detector_out2", int'(detector_out2), int'(m_pulse));
    chk("match_count2", int'(match_count2), int'(m_cnt2));
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] ln, input bit ov);
    step(0, 1, pat, ln, ov, 0, 0);
  endtask

  task automatic sbit(input bit b);
    step(0, 0, 8'h00, 4'd0, 0, 1, b);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 4'd0, 0, 0, 0);
  endtask

  task automatic stream7(input logic [6:0] s, input int p1, input int p2, input string tag);
    for (int i = 6; i >= 0; i--) begin
      sbit(s[i]);
      chk({tag, "_pulse"}, int'(detector_out), ((7 - i) == p1 || (7 - i) == p2) ? 1 : 0);
    end
  endtask

  initial begin
    logic [7:0] a5;
    int         pulses;
    bit         rst_r, ld_r, v_r, ov_r;
    logic [3:0] ln_r;

    step(1, 0, 8'h00, 4'd0, 0, 0, 0);
    step(1, 0, 8'h00, 4'd0, 0, 0, 0);
    chk("reset_armed", int'(armed), 0);
    chk("reset_count", int'(match_count), 0);

    // Overlapping 10101 on 1010101: pulses after bits 5 and 7.
    load(8'b10101, 4'd5, 1);
    chk("t1_armed", int'(armed), 1);
    stream7(7'b1010101, 5, 7, "t1");
    chk("t1_count", int'(match_count), 2);

    // Non-overlapping: single pulse after bit 5.
    load(8'b10101, 4'd5, 0);
    chk("t2_cleared", int'(match_count), 0);
    stream7(7'b1010101, 5, 99, "t2");
    chk("t2_count", int'(match_count), 1);

    // in_valid gaps between bits 2 and 3.
    load(8'b10101, 4'd5, 1);
    sbit(1); sbit(0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t3_gap_pulse", int'(detector_out), 0);
    end
    sbit(1); sbit(0);
    chk("t3_early", int'(detector_out), 0);
    sbit(1);
    chk("t3_pulse", int'(detector_out), 1);

    // Illegal length, then recovery.
    load(8'b10101, 4'd0, 1);
    chk("t4_err", int'(cfg_err), 1);
    chk("t4_armed", int'(armed), 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      sbit(i[0] ? 1'b0 : 1'b1);
      pulses += int'(detector_out);
    end
    chk("t4_nopulse", pulses, 0);
    load(8'b011, 4'd3, 1);
    chk("t4_err_clr", int'(cfg_err), 0);
    sbit(0); sbit(1);
    chk("t4_early", int'(detector_out), 0);
    sbit(1);
    chk("t4_pulse", int'(detector_out), 1);
    load(8'h00, 4'd12, 0);
    chk("t4_len12_err", int'(cfg_err), 1);

    // Counter saturation on the 2-bit instance.
    a5 = 8'hA5;
    load(a5, 4'd8, 0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        sbit(a5[i]);
        pulses += int'(detector_out);
      end
    end
    chk("t5_pulses", pulses, 4);
    chk("t5_count16", int'(match_count), 4);
    chk("t5_count2", int'(match_count2), 3);

    // Reset mid-stream loses the partial match.
    load(8'b10101, 4'd5, 1);
    sbit(1); sbit(0); sbit(1); sbit(0);
    step(1, 0, 8'h00, 4'd0, 0, 0, 0);
    sbit(1);
    chk("t6_pulse", int'(detector_out), 0);
    chk("t6_armed", int'(armed), 0);
    chk("t6_count", int'(match_count), 0);

    // Load coincident with a valid bit: bit discarded.
    step(0, 1, 8'h01, 4'd1, 1, 1, 1);
    chk("t7_coincident", int'(detector_out), 0);
    sbit(1);
    chk("t7_len1", int'(detector_out), 1);
    sbit(0);
    chk("t7_len1_zero", int'(detector_out), 0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      int r;
      r     = int'($urandom_range(0, 999));
      rst_r = (r < 3);
      ld_r  = (r >= 3 && r < 30);
      ln_r  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(1, 4));
      ov_r  = 1'($urandom_range(0, 1));
      v_r   = ($urandom_range(0, 4) != 0);
      step(rst_r, ld_r, 8'($urandom), ln_r, ov_r, v_r, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
